sound_sequencer: RTL and testbench

- Controller that sequences the 8-bit sawtooth dac_counter to play short game sound effects: eat, crash and win.
- Arbitrates three one-shot sound requests from game logic by fixed priority.
- Steps through a per-sound note table (period, duration) and drives the counter's at_max enable so the ramp produces the note pitch.
- Sits between game FSM and dac_counter; its at_max output connects directly to dac_counter.at_max.

---
 rtl/sound_sequencer_pkg.sv | 44 ++++
 rtl/sound_sequencer_if.sv | 21 ++
 rtl/sound_sequencer_tone_gen.sv | 38 +++
 rtl/sound_sequencer.sv | 113 +++++++++++
 tb/tb_sound_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sound_sequencer_pkg.sv
// Shared types, note tables and lookup for the sound sequencer.
package sound_pkg;

    localparam int MAX_NOTES = 4;

    typedef enum logic [1:0] {
        SND_NONE  = 2'd0,
        SND_EAT   = 2'd1,
        SND_CRASH = 2'd2,
        SND_WIN   = 2'd3
    } sound_id_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] period;
        logic [3:0] dur;
    } note_t;

    // dur 0 marks the end of a table; period 0 is a rest
    localparam note_t EAT_TBL [MAX_NOTES] = '{
        '{8'd40, 4'd2}, '{8'd30, 4'd2}, '{8'd0, 4'd0}, '{8'd0, 4'd0}};
    localparam note_t CRASH_TBL [MAX_NOTES] = '{
        '{8'd200, 4'd4}, '{8'd0, 4'd1}, '{8'd250, 4'd6}, '{8'd0, 4'd0}};
    localparam note_t WIN_TBL [MAX_NOTES] = '{
        '{8'd50, 4'd2}, '{8'd40, 4'd2}, '{8'd30, 4'd2}, '{8'd20, 4'd4}};

    function automatic note_t get_note(sound_id_e id, logic [1:0] idx);
        note_t n;
        n = '0;
        case (id)
            SND_EAT:   n = EAT_TBL[idx];
            SND_CRASH: n = CRASH_TBL[idx];
            SND_WIN:   n = WIN_TBL[idx];
            default:   n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Game-logic <-> sound sequencer signal bundle.
interface sound_sequencer_if;
    logic       req_eat;
    logic       req_crash;
    logic       req_win;
    logic       mute;
    logic       at_max;
    logic       busy;
    logic [1:0] sound_id;
    logic       done;

    modport master (
        output req_eat, req_crash, req_win, mute,
        input  at_max, busy, sound_id, done
    );

    modport slave (
        input  req_eat, req_crash, req_win, mute,
        output at_max, busy, sound_id, done
    );
endinterface

// File: rtl/sound_sequencer_tone_gen.sv
// Tone down-counter: registered at_max high for `period` cycles, low for one.
module tone_gen (
    input  logic       clk,
    input  logic       nRst,
    input  logic       en,
    input  logic       restart,
    input  logic       mute,
    input  logic [7:0] period,
    output logic       at_max
);
    logic [7:0] tc_q, tc_d;
    logic       at_max_q, at_max_d;

    // tc counts period..1 while high, 0 is the single low cycle; a rest stays at 0
    always_comb begin
        tc_d = tc_q;
        if (!en) begin
            tc_d = '0;
        end else if (restart || tc_q == '0) begin
            tc_d = period;
        end else begin
            tc_d = tc_q - 8'd1;
        end
        at_max_d = en && !mute && (tc_d != '0);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tc_q     <= '0;
            at_max_q <= 1'b0;
        end else begin
            tc_q     <= tc_d;
            at_max_q <= at_max_d;
        end
    end

    assign at_max = at_max_q;
endmodule

// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: arbitrates requests and walks note tables to drive dac_counter.at_max.
// state | meaning
// IDLE  | no sound; any request starts note 0 of the highest-priority sound
// PLAY  | stepping notes; strictly higher-priority request preempts
// DONE  | one-cycle done pulse, requests dropped
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int DUR_DIV = 100000
) (
    input  logic              clk,
    input  logic              nRst,
    sound_sequencer_if.slave  bus
);
    localparam int DUR_W = $clog2(15 * DUR_DIV);

    state_e            state_q, state_d;
    sound_id_e         sound_id_q, sound_id_d;
    logic [1:0]        note_idx_q, note_idx_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              restart;
    sound_id_e         req_id;
    note_t             next_note;
    note_t             cur_note;

    function automatic logic [DUR_W-1:0] load_dur(note_t n);
        return DUR_W'(n.dur) * DUR_W'(DUR_DIV) - DUR_W'(1);
    endfunction

    always_comb begin
        req_id = SND_NONE;
        if (bus.req_win)        req_id = SND_WIN;
        else if (bus.req_crash) req_id = SND_CRASH;
        else if (bus.req_eat)   req_id = SND_EAT;

        state_d    = state_q;
        sound_id_d = sound_id_q;
        note_idx_d = note_idx_q;
        dur_cnt_d  = dur_cnt_q;
        restart    = 1'b0;
        next_note  = get_note(sound_id_q, note_idx_q + 2'd1);

        case (state_q)
            ST_IDLE, ST_PLAY: begin
                // sound_id is NONE in IDLE, so any request wins there
                if (req_id > sound_id_q) begin
                    state_d    = ST_PLAY;
                    sound_id_d = req_id;
                    note_idx_d = 2'd0;
                    dur_cnt_d  = load_dur(get_note(req_id, 2'd0));
                    restart    = 1'b1;
                end else if (state_q == ST_PLAY) begin
                    if (dur_cnt_q == '0) begin
                        if (note_idx_q == 2'(MAX_NOTES - 1) || next_note.dur == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            note_idx_d = note_idx_q + 2'd1;
                            dur_cnt_d  = load_dur(next_note);
                            restart    = 1'b1;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                sound_id_d = SND_NONE;
                note_idx_d = 2'd0;
                dur_cnt_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        cur_note = get_note(sound_id_d, note_idx_d);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            sound_id_q <= SND_NONE;
            note_idx_q <= 2'd0;
            dur_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sound_id_q <= sound_id_d;
            note_idx_q <= note_idx_d;
            dur_cnt_q  <= dur_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    tone_gen u_tone_gen (
        .clk     (clk),
        .nRst    (nRst),
        .en      (state_d == ST_PLAY),
        .restart (restart),
        .mute    (bus.mute),
        .period  (cur_note.period),
        .at_max  (bus.at_max)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sound_id = sound_id_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: timeline model of each sound plus directed literal checks.
module tb_sound_sequencer;
    localparam int DIV = 100;

    // row = sound id (0 none, 1 eat, 2 crash, 3 win)
    localparam int PER [4][4] = '{'{0, 0, 0, 0}, '{40, 30, 0, 0}, '{200, 0, 250, 0}, '{50, 40, 30, 20}};
    localparam int DUR [4][4] = '{'{0, 0, 0, 0}, '{2, 2, 0, 0}, '{4, 1, 6, 0}, '{2, 2, 2, 4}};

    logic clk = 1'b0;
    logic nRst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run_cmp = 0;

    sound_sequencer_if sif ();

    sound_sequencer #(.DUR_DIV(DIV)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int sound_len(int s);
        int len = 0;
        for (int j = 0; j < 4; j++) begin
            if (DUR[s][j] == 0) break;
            len += DUR[s][j] * DIV;
        end
        return len;
    endfunction

    // at_max for elapsed cycle t since the sound started
    function automatic int tone(int s, int t);
        int cum = 0;
        for (int j = 0; j < 4; j++) begin
            int len;
            if (DUR[s][j] == 0) break;
            len = DUR[s][j] * DIV;
            if (t < cum + len) begin
                int p  = PER[s][j];
                int ti = t - cum;
                return (p > 0 && (ti % (p + 1)) < p) ? 1 : 0;
            end
            cum += len;
        end
        return 0;
    endfunction

    int m_snd = 0;
    int m_t = 0;
    bit m_in_done = 0;
    int e_at = 0, e_busy = 0, e_done = 0, e_id = 0;

    always @(posedge clk or negedge nRst) begin
        int req;
        if (!nRst) begin
            m_snd = 0; m_t = 0; m_in_done = 0;
            e_at = 0; e_busy = 0; e_done = 0; e_id = 0;
        end else begin
            req = sif.req_win ? 3 : sif.req_crash ? 2 : sif.req_eat ? 1 : 0;
            if (m_in_done) begin
                m_in_done = 0;
                m_snd = 0;
            end else if (req > m_snd) begin
                m_snd = req;
                m_t = 0;
            end else if (m_snd != 0) begin
                m_t++;
                if (m_t >= sound_len(m_snd)) m_in_done = 1;
            end
            e_done = m_in_done ? 1 : 0;
            e_busy = (m_snd != 0) ? 1 : 0;
            e_id   = m_snd;
            e_at   = (!m_in_done && m_snd != 0 && !sif.mute) ? tone(m_snd, m_t) : 0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_at_max",   sif.at_max,   e_at);
            chk("model_busy",     sif.busy,     e_busy);
            chk("model_done",     sif.done,     e_done);
            chk("model_sound_id", sif.sound_id, e_id);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int which);
        sif.req_eat   = (which == 1 || which == 4);
        sif.req_crash = (which == 2 || which == 4);
        sif.req_win   = (which == 3 || which == 4);
        @(negedge clk);
        sif.req_eat = 0; sif.req_crash = 0; sif.req_win = 0;
    endtask

    int n_at, n_busy, n_done, done_cyc;

    initial begin
        sif.req_eat = 0; sif.req_crash = 0; sif.req_win = 0; sif.mute = 0;
        wait_cyc(3);
        chk("rst_at_max", sif.at_max, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_sound_id", sif.sound_id, 0);
        nRst = 1;
        run_cmp = 1;
        wait_cyc(1);

        // eat, full play
        pulse(1);
        chk("eat_c1_id", sif.sound_id, 1);
        chk("eat_c1_at", sif.at_max, 1);
        wait_cyc(39);  chk("eat_c40_at", sif.at_max, 1);
        wait_cyc(1);   chk("eat_c41_at", sif.at_max, 0);
        wait_cyc(1);   chk("eat_c42_at", sif.at_max, 1);
        wait_cyc(159); chk("eat_c201_at", sif.at_max, 1);
        wait_cyc(30);  chk("eat_c231_at", sif.at_max, 0);
        wait_cyc(170);
        chk("eat_c401_done", sif.done, 1);
        chk("eat_c401_busy", sif.busy, 1);
        chk("eat_c401_at", sif.at_max, 0);
        wait_cyc(1);
        chk("eat_c402_busy", sif.busy, 0);
        chk("eat_c402_id", sif.sound_id, 0);
        wait_cyc(3);

        // crash preempts eat in note 1, eat during crash is dropped
        pulse(1);
        wait_cyc(249);
        pulse(2);
        chk("pre_id", sif.sound_id, 2);
        chk("pre_at", sif.at_max, 1);
        chk("pre_done", sif.done, 0);
        wait_cyc(5);
        pulse(1);
        chk("crash_keep_id", sif.sound_id, 2);
        wait_cyc(443); chk("crash_rest_at", sif.at_max, 0);
        wait_cyc(51);  chk("crash_c501_at", sif.at_max, 1);
        wait_cyc(600); chk("crash_c1101_done", sif.done, 1);
        wait_cyc(1);   chk("crash_after_busy", sif.busy, 0);
        wait_cyc(2);

        // win muted
        sif.mute = 1;
        n_at = 0; n_busy = 0; n_done = 0; done_cyc = 0;
        pulse(3);
        for (int i = 0; i < 1005; i++) begin
            if (sif.at_max) n_at++;
            if (sif.busy) n_busy++;
            if (sif.done) begin n_done++; done_cyc = i + 1; end
            @(negedge clk);
        end
        chk("mute_at_count", n_at, 0);
        chk("mute_busy_count", n_busy, 1001);
        chk("mute_done_count", n_done, 1);
        chk("mute_done_cycle", done_cyc, 1001);
        sif.mute = 0;
        wait_cyc(2);

        // simultaneous requests, then async reset mid-PLAY
        pulse(4);
        chk("simul_id", sif.sound_id, 3);
        wait_cyc(10);
        pulse(2);
        chk("win_keep_id", sif.sound_id, 3);
        wait_cyc(10);
        #2 nRst = 0;
        #1;
        chk("arst_at_max", sif.at_max, 0);
        chk("arst_busy", sif.busy, 0);
        chk("arst_done", sif.done, 0);
        chk("arst_sound_id", sif.sound_id, 0);
        wait_cyc(2);
        nRst = 1;
        wait_cyc(1);
        chk("post_rst_busy", sif.busy, 0);
        pulse(1);
        chk("post_rst_id", sif.sound_id, 1);
        chk("post_rst_at", sif.at_max, 1);
        wait_cyc(40);  chk("post_rst_c41_at", sif.at_max, 0);
        wait_cyc(360); chk("post_rst_done", sif.done, 1);
        wait_cyc(3);

        run_cmp = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
